// File: rtl/lfo_pkg.sv
// Shared types and constants for the LFO generator and its shaper.
package lfo_pkg;

  typedef enum logic [1:0] {
    WAVE_TRI    = 2'd0,
    WAVE_SAW_UP = 2'd1,
    WAVE_SQUARE = 2'd2,
    WAVE_SAW_DN = 2'd3
  } wave_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int unsigned LFO_DEPTH_W = 8;

endpackage

// File: rtl/lfo_shaper.sv
// Combinational phase-to-sample shaper: triangle, saw-up, square, saw-down.
module lfo_shaper
  import lfo_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PHASE_W = 16
) (
  input  logic [PHASE_W-1:0] i_phase,
  input  logic [1:0]         i_wave,
  output logic [DATA_W-1:0]  o_sample
);

  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] w_u;
  logic [DATA_W-1:0] w_dbl;
  logic [DATA_W-1:0] w_tri;

  assign w_u   = i_phase[PHASE_W-1 -: DATA_W];
  assign w_dbl = {w_u[DATA_W-2:0], 1'b0};
  assign w_tri = w_u[DATA_W-1] ? ~w_dbl : w_dbl;

  // XOR with the MSB mask converts offset binary to two's complement.
  always_comb begin
    o_sample = '0;
    case (wave_t'(i_wave))
      WAVE_TRI:    o_sample = w_tri ^ MSB_MASK;
      WAVE_SAW_UP: o_sample = w_u ^ MSB_MASK;
      WAVE_SQUARE: o_sample = w_u[DATA_W-1] ? MSB_MASK : ~MSB_MASK;
      WAVE_SAW_DN: o_sample = ~(w_u ^ MSB_MASK);
    endcase
  end

endmodule

// File: rtl/lfo_generator.sv
// Phase-accumulator LFO with period-gated rate/shape changes.
// Optional LFO_DEPTH_EN adds an i_depth amplitude scaler (one extra register stage).
module lfo_generator
  import lfo_pkg::*;
#(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          PHASE_W  = 16,
  parameter int unsigned          FREQ_W   = 3,
  parameter logic [PHASE_W-1:0]   BASE_INC = 16'd256,
  parameter logic [DATA_W-1:0]    IDLE_VAL = 16'h7000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_tick,
  input  logic [FREQ_W-1:0]      i_freq,
  input  logic [1:0]             i_wave,
`ifdef LFO_DEPTH_EN
  input  logic [LFO_DEPTH_W-1:0] i_depth,
`endif
  output logic [DATA_W-1:0]      o_wave,
  output logic                   o_valid,
  output logic                   o_wrap
);

  state_t             r_state, w_state_next;
  logic [PHASE_W-1:0] r_phase, w_phase_next;
  logic [PHASE_W-1:0] r_inc, w_inc_next;
  wave_t              r_wave, w_wave_next;
  logic [PHASE_W-1:0] r_pend_inc, w_pend_inc_next;
  wave_t              r_pend_wave, w_pend_wave_next;
  logic [DATA_W-1:0]  r_out, w_out_next;
  logic               r_valid, w_valid_next;
  logic               r_wrap, w_wrap_next;

  logic [PHASE_W-1:0] w_freq_p1;
  logic [PHASE_W-1:0] w_new_inc;
  logic [PHASE_W-1:0] w_sum;
  logic               w_carry;
  logic [DATA_W-1:0]  w_shape;

  assign w_freq_p1        = PHASE_W'(i_freq) + PHASE_W'(1);
  assign w_new_inc        = w_freq_p1 * BASE_INC;
  assign {w_carry, w_sum} = {1'b0, r_phase} + {1'b0, r_inc};

  lfo_shaper #(
    .DATA_W  (DATA_W),
    .PHASE_W (PHASE_W)
  ) u_shaper (
    .i_phase  (w_sum),
    .i_wave   (r_wave),
    .o_sample (w_shape)
  );

  always_comb begin
    w_state_next     = r_state;
    w_phase_next     = r_phase;
    w_inc_next       = r_inc;
    w_wave_next      = r_wave;
    w_pend_inc_next  = r_pend_inc;
    w_pend_wave_next = r_pend_wave;
    w_out_next       = r_out;
    w_valid_next     = 1'b0;
    w_wrap_next      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_out_next = IDLE_VAL;
        if (i_start) begin
          w_state_next     = S_RUN;
          w_phase_next     = '0;
          w_inc_next       = w_new_inc;
          w_wave_next      = wave_t'(i_wave);
          w_pend_inc_next  = w_new_inc;
          w_pend_wave_next = wave_t'(i_wave);
        end
      end
      S_RUN: begin
        if (!i_start) begin
          w_state_next = S_IDLE;
          w_phase_next = '0;
          w_out_next   = IDLE_VAL;
        end else if (i_tick) begin
          w_phase_next = w_sum;
          w_out_next   = w_shape;
          w_valid_next = 1'b1;
          w_wrap_next  = w_carry;
          // Commit what was pending before this tick; the new sample uses the old settings.
          if (w_carry) begin
            w_inc_next  = r_pend_inc;
            w_wave_next = r_pend_wave;
          end
          w_pend_inc_next  = w_new_inc;
          w_pend_wave_next = wave_t'(i_wave);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_inc       <= '0;
      r_wave      <= WAVE_TRI;
      r_pend_inc  <= '0;
      r_pend_wave <= WAVE_TRI;
      r_out       <= IDLE_VAL;
      r_valid     <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_inc       <= w_inc_next;
      r_wave      <= w_wave_next;
      r_pend_inc  <= w_pend_inc_next;
      r_pend_wave <= w_pend_wave_next;
      r_out       <= w_out_next;
      r_valid     <= w_valid_next;
      r_wrap      <= w_wrap_next;
    end
  end

`ifdef LFO_DEPTH_EN
  localparam int unsigned PROD_W = DATA_W + LFO_DEPTH_W + 1;

  logic [LFO_DEPTH_W-1:0] r_depth;
  logic [DATA_W-1:0]      r_out2;
  logic                   r_valid2;
  logic                   r_wrap2;
  logic signed [PROD_W-1:0] w_prod;

  assign w_prod = PROD_W'($signed(r_out)) * PROD_W'($signed({1'b0, r_depth}));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth  <= '0;
      r_out2   <= IDLE_VAL;
      r_valid2 <= 1'b0;
      r_wrap2  <= 1'b0;
    end else begin
      if (r_state == S_RUN && i_start && i_tick) r_depth <= i_depth;
      // Idle output bypasses the scaler so it stays at IDLE_VAL.
      if (w_state_next == S_IDLE) begin
        r_out2   <= IDLE_VAL;
        r_valid2 <= 1'b0;
        r_wrap2  <= 1'b0;
      end else begin
        r_valid2 <= r_valid;
        r_wrap2  <= r_wrap;
        if (r_valid) r_out2 <= w_prod[DATA_W+LFO_DEPTH_W-1:LFO_DEPTH_W];
      end
    end
  end

  assign o_wave  = r_out2;
  assign o_valid = r_valid2;
  assign o_wrap  = r_wrap2;
`else
  assign o_wave  = r_out;
  assign o_valid = r_valid;
  assign o_wrap  = r_wrap;
`endif

endmodule

// File: tb/tb_lfo_generator.sv
// Self-checking bench for lfo_generator: directed steps plus randomized run against
// an arithmetic reference model.
module tb_lfo_generator;
  import lfo_pkg::*;

  localparam int IDLE = 'h7000;
`ifdef LFO_DEPTH_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tick  = 1'b0;
  logic [2:0]  freq  = '0;
  logic [1:0]  wave  = '0;
  logic [7:0]  depth = 8'd255;
  logic [15:0] o_wave;
  logic        o_valid;
  logic        o_wrap;

  int    n_checks = 0;
  int    n_errors = 0;
  string sect     = "reset";

  // Reference model state
  bit m_run;
  int m_phase, m_inc, m_wave, m_pinc, m_pwave;
  int m_o1, m_d1;
  bit m_v1, m_w1;
  int e_out;
  bit e_valid, e_wrap;

  always #5 clk = ~clk;

  lfo_generator dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_tick  (tick),
    .i_freq  (freq),
    .i_wave  (wave),
`ifdef LFO_DEPTH_EN
    .i_depth (depth),
`endif
    .o_wave  (o_wave),
    .o_valid (o_valid),
    .o_wrap  (o_wrap)
  );

  function automatic int shape(input int u, input int w);
    case (w)
      0:       return (u < 32768) ? 2 * u - 32768 : 32767 - 2 * (u - 32768);
      1:       return u - 32768;
      2:       return (u < 32768) ? 32767 : -32768;
      default: return 32767 - u;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", sect, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_inc = 0; m_wave = 0; m_pinc = 0; m_pwave = 0;
    m_o1 = IDLE; m_v1 = 0; m_w1 = 0; m_d1 = 0;
    e_out = IDLE; e_valid = 0; e_wrap = 0;
  endtask

  task automatic model_step(input bit s, input bit t, input int f, input int w, input int d);
`ifdef LFO_DEPTH_EN
    int po = m_o1;
    int pd = m_d1;
    bit pv = m_v1;
    bit pw = m_w1;
`endif
    int nxt;
    m_v1 = 0;
    m_w1 = 0;
    if (!m_run) begin
      m_o1 = IDLE;
      if (s) begin
        m_run = 1; m_phase = 0;
        m_inc = ((f + 1) * 256) % 65536; m_wave = w;
        m_pinc = m_inc; m_pwave = w;
      end
    end else if (!s) begin
      m_run = 0; m_phase = 0; m_o1 = IDLE;
    end else if (t) begin
      nxt     = m_phase + m_inc;
      m_w1    = (nxt >= 65536);
      m_phase = nxt % 65536;
      m_o1    = shape(m_phase, m_wave);
      m_v1    = 1;
      m_d1    = d;
      if (m_w1) begin
        m_inc = m_pinc; m_wave = m_pwave;
      end
      m_pinc  = ((f + 1) * 256) % 65536;
      m_pwave = w;
    end
`ifdef LFO_DEPTH_EN
    if (!m_run) begin
      e_out = IDLE; e_valid = 0; e_wrap = 0;
    end else if (pv) begin
      e_out = (po * pd) >>> 8; e_valid = 1; e_wrap = pw;
    end else begin
      e_valid = 0; e_wrap = 0;
    end
`else
    e_out = m_o1; e_valid = m_v1; e_wrap = m_w1;
`endif
  endtask

  task automatic cyc(input bit s, input bit t, input int f, input int w);
    @(negedge clk);
    start = s; tick = t; freq = 3'(f); wave = 2'(w);
    depth = 8'($urandom);
    @(posedge clk);
    model_step(s, t, f, w, int'(depth));
    #1;
    check("o_wave", 32'(o_wave), 32'(e_out & 'hFFFF));
    check("o_valid", 32'(o_valid), 32'(e_valid));
    check("o_wrap", 32'(o_wrap), 32'(e_wrap));
  endtask

  initial begin
    int first_wrap;
    int second_wrap;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wave", 32'(o_wave), 32'(IDLE));
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_wrap", 32'(o_wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    sect = "idle";
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, $urandom_range(0, 7), $urandom_range(0, 3));

    sect = "tri_f0";
    cyc(1'b1, 1'b1, 0, 0);
    check("start_holds_idle", 32'(o_wave), 32'(IDLE));
    first_wrap = -1; second_wrap = -1;
    for (int i = 1; i <= 600; i++) begin
      cyc(1'b1, 1'b1, 0, 0);
`ifndef LFO_DEPTH_EN
      if (i == 1) check("first_sample", 32'(o_wave), 32'h8200);
      if (i == 128) check("peak", 32'(o_wave), 32'h7FFF);
`endif
      if (o_wrap) begin
        if (first_wrap < 0) first_wrap = i;
        else if (second_wrap < 0) second_wrap = i;
      end
    end
    check("first_wrap_tick", 32'(first_wrap), 32'(255 + LAT));
    check("second_wrap_tick", 32'(second_wrap), 32'(511 + LAT));

    sect = "stop_tick";
    cyc(1'b0, 1'b1, 0, 0);
    check("stop_wave", 32'(o_wave), 32'(IDLE));
    check("stop_valid", 32'(o_valid), 32'd0);

    sect = "square_slow";
    cyc(1'b1, 1'b0, 1, 2);
    for (int i = 1; i <= 600; i++) cyc(1'b1, (i % 4) == 0, 1, 2);

    sect = "mid_change";
    cyc(1'b0, 1'b0, 0, 1);
    cyc(1'b1, 1'b1, 0, 1);
    first_wrap = -1; second_wrap = -1;
    for (int i = 1; i <= 400; i++) begin
      cyc(1'b1, 1'b1, (i >= 100) ? 3 : 0, 1);
      if (o_wrap) begin
        if (first_wrap < 0) first_wrap = i;
        else if (second_wrap < 0) second_wrap = i;
      end
    end
    check("wrap_before_change", 32'(first_wrap), 32'(255 + LAT));
    check("wrap_after_change", 32'(second_wrap), 32'(319 + LAT));

    sect = "restart";
    cyc(1'b0, 1'b1, 0, 1);
    check("stop_wave", 32'(o_wave), 32'(IDLE));
    cyc(1'b1, 1'b1, 0, 0);
    cyc(1'b1, 1'b1, 0, 0);
`ifndef LFO_DEPTH_EN
    check("restart_first", 32'(o_wave), 32'h8200);
`endif
    cyc(1'b1, 1'b1, 0, 0);

    sect = "random";
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 7), $urandom_range(0, 3));

    sect = "async_rst";
    cyc(1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 2, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 2, 1);
    #1;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    model_reset();
    check("arst_wave", 32'(o_wave), 32'(IDLE));
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_wrap", 32'(o_wrap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 0, 0);
    cyc(1'b1, 1'b1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
